// File: rtl/led_pwm_pkg.sv
// Register map, CTRL layout and bus byte-merge helper for the led_pwm_regs peripheral.
package led_pwm_pkg;

  localparam int unsigned MASK_ADDR = 0;
  localparam int unsigned CTRL_ADDR = 1;
  localparam int unsigned DUTY_BASE = 2;

  localparam int unsigned CTRL_PWM_EN_BIT     = 0;
  localparam int unsigned CTRL_BLINK_EN_BIT   = 1;
  localparam int unsigned CTRL_BLINK_HALF_LSB = 8;

  localparam int unsigned BUS_W = 16;

  typedef struct packed {
    logic [7:0] blink_half;
    logic [5:0] rsvd;
    logic       blink_en;
    logic       pwm_en;
  } ctrl_t;

  // Replace the bytes of old_v selected by sel with the corresponding bytes of new_v.
  function automatic logic [BUS_W-1:0] byte_merge(input logic [BUS_W-1:0] old_v,
                                                  input logic [BUS_W-1:0] new_v,
                                                  input logic [1:0]       sel);
    logic [BUS_W-1:0] v;
    v = old_v;
    if (sel[0]) v[7:0]  = new_v[7:0];
    if (sel[1]) v[15:8] = new_v[15:8];
    return v;
  endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// Prescaler, PWM counter and period-boundary strobe; blink phase when LED_PWM_BLINK_EN is defined.
module led_pwm_timebase #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned PRESCALE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_pwm_en,
`ifdef LED_PWM_BLINK_EN
  input  logic                i_blink_en,
  input  logic [7:0]          i_blink_half,
`endif
  output logic [PWM_BITS-1:0] o_pwm_cnt,
  output logic                o_boundary_c,
  output logic                o_blink_phase
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]    r_pre_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                w_tick;

  assign w_tick       = (r_pre_cnt == PRE_W'(PRESCALE - 1));
  assign o_boundary_c = i_pwm_en & w_tick & (r_pwm_cnt == '1);
  assign o_pwm_cnt    = r_pwm_cnt;

  // Both counters are held at zero while PWM is disabled so a re-enable starts a fresh period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
    end else if (!i_pwm_en) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
      if (w_tick) r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end
  end

`ifdef LED_PWM_BLINK_EN
  logic [7:0] r_blink_cnt;
  logic       r_blink_phase;

  // Boundaries only occur with PWM enabled, so the count freezes while PWM is off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (!i_blink_en) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (o_boundary_c) begin
      if (r_blink_cnt == i_blink_half) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 8'd1;
      end
    end
  end

  assign o_blink_phase = r_blink_phase;
`else
  assign o_blink_phase = 1'b0;
`endif

endmodule

// File: rtl/led_pwm_regs.sv
// Bus-mapped NUM_LEDS-channel LED controller with per-channel shadowed PWM duty.
// Optional blink gating is built when LED_PWM_BLINK_EN is defined.
module led_pwm_regs
  import led_pwm_pkg::*;
#(
  parameter  int unsigned NUM_LEDS = 8,
  parameter  int unsigned PWM_BITS = 8,
  parameter  int unsigned PRESCALE = 16,
  localparam int unsigned ADDR_W   = $clog2(NUM_LEDS + 2)
) (
  input  logic                clk,
  input  logic                reset,
  output logic [NUM_LEDS-1:0] leds_val,
  input  logic                cs,
  input  logic [ADDR_W-1:0]   data_m_addr,
  input  logic [15:0]         data_m_data_in,
  output logic [15:0]         data_m_data_out,
  input  logic                data_m_access,
  output logic                data_m_ack,
  input  logic                data_m_wr_en,
  input  logic [1:0]          data_m_bytesel
);

`ifdef LED_PWM_BLINK_EN
  localparam logic [15:0] CTRL_WMASK = (16'hFF << CTRL_BLINK_HALF_LSB)
                                     | (16'd1 << CTRL_BLINK_EN_BIT)
                                     | (16'd1 << CTRL_PWM_EN_BIT);
`else
  localparam logic [15:0] CTRL_WMASK = 16'd1 << CTRL_PWM_EN_BIT;
`endif

  logic [NUM_LEDS-1:0] r_mask;
  ctrl_t               r_ctrl;
  logic [PWM_BITS-1:0] r_pend   [NUM_LEDS];
  logic [PWM_BITS-1:0] r_shadow [NUM_LEDS];
  logic                r_ack;
  logic [15:0]         r_rd_data;

  logic                w_access;
  logic                w_wr;
  logic                w_sel_mask;
  logic                w_sel_ctrl;
  logic [NUM_LEDS-1:0] w_sel_duty;
  logic [15:0]         w_rd_data;
  logic [PWM_BITS-1:0] w_pwm_cnt;
  logic                w_boundary_c;
  logic                w_blink_phase;
  logic                w_shadow_load;
  logic [NUM_LEDS-1:0] w_on;
  logic [NUM_LEDS-1:0] w_leds_next;

  assign w_access   = cs & data_m_access;
  assign w_wr       = w_access & data_m_wr_en;
  assign w_sel_mask = (data_m_addr == ADDR_W'(MASK_ADDR));
  assign w_sel_ctrl = (data_m_addr == ADDR_W'(CTRL_ADDR));

  always_comb begin
    w_sel_duty = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      w_sel_duty[i] = (data_m_addr == ADDR_W'(DUTY_BASE + i));
    end
  end

  // Readback mux; DUTY reads return the pending value, unmapped addresses read 0.
  always_comb begin
    w_rd_data = '0;
    if (w_sel_mask) w_rd_data = 16'(r_mask);
    if (w_sel_ctrl) w_rd_data = r_ctrl;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (w_sel_duty[i]) w_rd_data = 16'(r_pend[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '0;
      r_ctrl <= '0;
      for (int i = 0; i < NUM_LEDS; i++) r_pend[i] <= '0;
    end else if (w_wr) begin
      if (w_sel_mask) r_mask <= NUM_LEDS'(byte_merge(16'(r_mask), data_m_data_in, data_m_bytesel));
      if (w_sel_ctrl) r_ctrl <= byte_merge(r_ctrl, data_m_data_in, data_m_bytesel) & CTRL_WMASK;
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (w_sel_duty[i]) begin
          r_pend[i] <= PWM_BITS'(byte_merge(16'(r_pend[i]), data_m_data_in, data_m_bytesel));
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_ack     <= w_access;
      r_rd_data <= w_access ? w_rd_data : '0;
    end
  end

  assign data_m_ack      = r_ack;
  assign data_m_data_out = r_rd_data;

  led_pwm_timebase #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk           (clk),
    .reset         (reset),
    .i_pwm_en      (r_ctrl.pwm_en),
`ifdef LED_PWM_BLINK_EN
    .i_blink_en    (r_ctrl.blink_en),
    .i_blink_half  (r_ctrl.blink_half),
`endif
    .o_pwm_cnt     (w_pwm_cnt),
    .o_boundary_c  (w_boundary_c),
    .o_blink_phase (w_blink_phase)
  );

  // Shadows track pending freely while PWM is off, otherwise only at the period boundary.
  assign w_shadow_load = ~r_ctrl.pwm_en | w_boundary_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) r_shadow[i] <= '0;
    end else if (w_shadow_load) begin
      for (int i = 0; i < NUM_LEDS; i++) r_shadow[i] <= r_pend[i];
    end
  end

  always_comb begin
    w_on = '1;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (r_ctrl.pwm_en) w_on[i] = (w_pwm_cnt < r_shadow[i]);
    end
    w_leds_next = r_mask & w_on & {NUM_LEDS{~w_blink_phase}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) leds_val <= '0;
    else       leds_val <= w_leds_next;
  end

endmodule

// File: tb/tb_led_pwm_regs.sv
// Directed bench for led_pwm_regs (PRESCALE=1, 256-cycle PWM period); blink checks need LED_PWM_BLINK_EN.
module tb_led_pwm_regs;

  localparam int unsigned NUM_LEDS = 8;
  localparam int unsigned PWM_BITS = 8;
  localparam int unsigned PRESCALE = 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [NUM_LEDS-1:0] leds_val;
  logic                cs;
  logic [3:0]          data_m_addr;
  logic [15:0]         data_m_data_in;
  logic [15:0]         data_m_data_out;
  logic                data_m_access;
  logic                data_m_ack;
  logic                data_m_wr_en;
  logic [1:0]          data_m_bytesel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_pwm_regs #(
    .NUM_LEDS (NUM_LEDS),
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .leds_val        (leds_val),
    .cs              (cs),
    .data_m_addr     (data_m_addr),
    .data_m_data_in  (data_m_data_in),
    .data_m_data_out (data_m_data_out),
    .data_m_access   (data_m_access),
    .data_m_ack      (data_m_ack),
    .data_m_wr_en    (data_m_wr_en),
    .data_m_bytesel  (data_m_bytesel)
  );

  task automatic bus_idle();
    cs = 1'b0; data_m_access = 1'b0; data_m_wr_en = 1'b0;
    data_m_addr = '0; data_m_data_in = '0; data_m_bytesel = 2'b00;
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [15:0] data,
                           input logic [1:0] sel, output logic ack);
    @(negedge clk);
    cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b1;
    data_m_addr = addr; data_m_data_in = data; data_m_bytesel = sel;
    @(negedge clk);
    ack = data_m_ack;
    bus_idle();
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic ack, output logic [15:0] data);
    @(negedge clk);
    cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0;
    data_m_addr = addr; data_m_bytesel = 2'b11;
    @(negedge clk);
    ack  = data_m_ack;
    data = data_m_data_out;
    bus_idle();
  endtask

  // Returns at the first negedge where leds_val[0] has just gone 0 -> 1 (a period start).
  task automatic wait_rise(output logic ok);
    logic prev;
    ok   = 1'b0;
    prev = leds_val[0];
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!prev && leds_val[0]) begin
        ok = 1'b1;
        return;
      end
      prev = leds_val[0];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_idle();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (leds_val !== 8'h00) begin errors++; $display("FAIL reset_leds: got %h want 00", leds_val); end
    checks++; if (data_m_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", data_m_ack); end
    checks++; if (data_m_data_out !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", data_m_data_out); end
    for (int a = 0; a < 3; a++) begin
      cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0; data_m_addr = 4'(a);
      #1;
      checks++; if (data_m_ack !== 1'b0) begin errors++; $display("FAIL reset_rd_early_ack addr %0d: got %b want 0", a, data_m_ack); end
      @(negedge clk);
      checks++; if (data_m_ack !== 1'b1) begin errors++; $display("FAIL reset_rd_ack addr %0d: got %b want 1", a, data_m_ack); end
      checks++; if (data_m_data_out !== 16'h0000) begin errors++; $display("FAIL reset_rd_data addr %0d: got %h want 0000", a, data_m_data_out); end
      bus_idle();
      @(negedge clk);
      checks++; if (data_m_ack !== 1'b0) begin errors++; $display("FAIL reset_rd_ack_drop addr %0d: got %b want 0", a, data_m_ack); end
    end
  endtask

  task automatic test_mask();
    logic ack; logic [15:0] d;
    bus_write(4'd0, 16'h00A5, 2'b01, ack);
    checks++; if (leds_val !== 8'h00) begin errors++; $display("FAIL mask_latency: got %h want 00", leds_val); end
    @(negedge clk);
    checks++; if (leds_val !== 8'hA5) begin errors++; $display("FAIL mask_leds: got %h want a5", leds_val); end
    bus_write(4'd0, 16'hFF00, 2'b10, ack);
    bus_read(4'd0, ack, d);
    checks++; if (d !== 16'h00A5) begin errors++; $display("FAIL mask_hibyte: got %h want 00a5", d); end
    bus_write(4'd0, 16'h005A, 2'b00, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL sel00_ack: got %b want 1", ack); end
    bus_read(4'd0, ack, d);
    checks++; if (d !== 16'h00A5) begin errors++; $display("FAIL sel00_nowrite: got %h want 00a5", d); end
  endtask

  task automatic test_ctrl_bits();
    logic ack; logic [15:0] d;
    logic [15:0] exp_ctrl;
`ifdef LED_PWM_BLINK_EN
    exp_ctrl = 16'hFF03;
`else
    exp_ctrl = 16'h0001;
`endif
    bus_write(4'd1, 16'hFFFF, 2'b11, ack);
    bus_read(4'd1, ack, d);
    checks++; if (d !== exp_ctrl) begin errors++; $display("FAIL ctrl_bits: got %h want %h", d, exp_ctrl); end
    bus_write(4'd1, 16'h0000, 2'b11, ack);
  endtask

  task automatic test_pwm_duty();
    logic ack;
    int c0, c1, c2, c3;
    bus_write(4'd0, 16'h00FF, 2'b11, ack);
    bus_write(4'd2, 16'd64,  2'b11, ack);
    bus_write(4'd3, 16'd0,   2'b11, ack);
    bus_write(4'd4, 16'd255, 2'b11, ack);
    bus_write(4'd1, 16'h0001, 2'b11, ack);
    repeat (5) @(negedge clk);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    for (int n = 0; n < 768; n++) begin
      @(negedge clk);
      c0 += int'(leds_val[0]); c1 += int'(leds_val[1]);
      c2 += int'(leds_val[2]); c3 += int'(leds_val[3]);
    end
    checks++; if (c0 !== 192) begin errors++; $display("FAIL duty64: got %0d want 192", c0); end
    checks++; if (c1 !== 0)   begin errors++; $display("FAIL duty0: got %0d want 0", c1); end
    checks++; if (c2 !== 765) begin errors++; $display("FAIL duty255: got %0d want 765", c2); end
    checks++; if (c3 !== 0)   begin errors++; $display("FAIL duty_default: got %0d want 0", c3); end
  endtask

  task automatic test_mid_period();
    logic ok; logic rd_ack; logic [15:0] rd_data;
    int c1, c2;
    wait_rise(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_rise_timeout: got 0 want 1"); end
    c1 = 0; c2 = 0; rd_ack = 1'b0; rd_data = '0;
    for (int n = 0; n < 512; n++) begin
      if (n > 0) @(negedge clk);
      if (n < 256) c1 += int'(leds_val[0]); else c2 += int'(leds_val[0]);
      if (n == 12) begin rd_ack = data_m_ack; rd_data = data_m_data_out; end
      if (n == 10) begin
        cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b1;
        data_m_addr = 4'd2; data_m_data_in = 16'd200; data_m_bytesel = 2'b11;
      end else if (n == 11) begin
        data_m_wr_en = 1'b0;
      end else if (n == 12) begin
        bus_idle();
      end
    end
    checks++; if (c1 !== 64)  begin errors++; $display("FAIL mid_cur_period: got %0d want 64", c1); end
    checks++; if (c2 !== 200) begin errors++; $display("FAIL mid_next_period: got %0d want 200", c2); end
    checks++; if (rd_ack !== 1'b1) begin errors++; $display("FAIL mid_rd_ack: got %b want 1", rd_ack); end
    checks++; if (rd_data !== 16'd200) begin errors++; $display("FAIL mid_readback: got %0d want 200", rd_data); end
  endtask

  task automatic test_boundary_write();
    logic ok; logic ack; logic [15:0] d;
    int c [3];
    wait_rise(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bnd_rise_timeout: got 0 want 1"); end
    c[0] = 0; c[1] = 0; c[2] = 0;
    for (int n = 0; n < 768; n++) begin
      if (n > 0) @(negedge clk);
      c[n / 256] += int'(leds_val[0]);
      if (n == 254) begin
        cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b1;
        data_m_addr = 4'd2; data_m_data_in = 16'd32; data_m_bytesel = 2'b11;
      end else if (n == 255) begin
        bus_idle();
      end
    end
    checks++; if (c[0] !== 200) begin errors++; $display("FAIL bnd_p0: got %0d want 200", c[0]); end
    checks++; if (c[1] !== 200) begin errors++; $display("FAIL bnd_p1_old: got %0d want 200", c[1]); end
    checks++; if (c[2] !== 32)  begin errors++; $display("FAIL bnd_p2_new: got %0d want 32", c[2]); end
    bus_write(4'd10, 16'h0000, 2'b11, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL oor_wr_ack: got %b want 1", ack); end
    bus_read(4'd0, ack, d);
    checks++; if (d !== 16'h00FF) begin errors++; $display("FAIL oor_wr_alias: got %h want 00ff", d); end
    bus_read(4'd10, ack, d);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL oor_rd_ack: got %b want 1", ack); end
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL oor_rd_data: got %h want 0000", d); end
  endtask

  task automatic test_disable();
    logic ack;
    bus_write(4'd1, 16'h0000, 2'b11, ack);
    @(negedge clk);
    checks++; if (leds_val !== 8'hFF) begin errors++; $display("FAIL disable_static: got %h want ff", leds_val); end
    repeat (5) @(negedge clk);
    checks++; if (leds_val !== 8'hFF) begin errors++; $display("FAIL disable_hold: got %h want ff", leds_val); end
  endtask

`ifdef LED_PWM_BLINK_EN
  task automatic test_blink();
    logic ok; logic ack;
    int s [12];
    int last, bad, nchg;
    bus_write(4'd2, 16'd255, 2'b11, ack);
    bus_write(4'd1, 16'h0203, 2'b11, ack);
    wait_rise(ok);
    checks++; if (!ok) begin errors++; $display("FAIL blink_rise_timeout: got 0 want 1"); end
    for (int k = 0; k < 12; k++) s[k] = 0;
    for (int n = 0; n < 12 * 256; n++) begin
      if (n > 0) @(negedge clk);
      s[n / 256] += int'(leds_val[0]);
    end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (s[k] != 0 && s[k] != 255) begin errors++; $display("FAIL blink_period %0d: got %0d want 0 or 255", k, s[k]); end
    end
    last = -1; bad = 0; nchg = 0;
    for (int k = 1; k < 12; k++) begin
      if ((s[k] == 0) != (s[k-1] == 0)) begin
        if (last >= 0 && k - last != 3) bad++;
        last = k;
        nchg++;
      end
    end
    checks++;
    if (bad != 0 || nchg < 3) begin errors++; $display("FAIL blink_3on_3off: got %0d bad runs %0d toggles want 0 bad >=3 toggles", bad, nchg); end
  endtask
`endif

  task automatic test_reset_mid();
    logic ack;
    bus_write(4'd0, 16'h00FF, 2'b11, ack);
    @(negedge clk);
    checks++; if (leds_val !== 8'hFF) begin errors++; $display("FAIL rst_pre_leds: got %h want ff", leds_val); end
    cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0; data_m_addr = 4'd0;
    @(posedge clk); #2;
    checks++; if (data_m_data_out !== 16'h00FF) begin errors++; $display("FAIL rst_pre_data: got %h want 00ff", data_m_data_out); end
    reset = 1'b1;
    #1;
    checks++; if (leds_val !== 8'h00) begin errors++; $display("FAIL rst_async_leds: got %h want 00", leds_val); end
    checks++; if (data_m_ack !== 1'b0) begin errors++; $display("FAIL rst_async_ack: got %b want 0", data_m_ack); end
    checks++; if (data_m_data_out !== 16'h0000) begin errors++; $display("FAIL rst_async_data: got %h want 0000", data_m_data_out); end
    @(posedge clk); #1;
    checks++; if (data_m_ack !== 1'b0) begin errors++; $display("FAIL rst_held_ack: got %b want 0", data_m_ack); end
    @(negedge clk);
    reset = 1'b0;
    bus_idle();
    @(negedge clk);
    checks++; if (data_m_ack !== 1'b0) begin errors++; $display("FAIL rst_dropped_ack: got %b want 0", data_m_ack); end
  endtask

  task automatic test_post_reset();
    logic ack; logic [15:0] d;
    bus_read(4'd0, ack, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL post_rst_mask: got %h want 0000", d); end
    bus_read(4'd1, ack, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL post_rst_ctrl: got %h want 0000", d); end
    bus_read(4'd2, ack, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL post_rst_duty0: got %h want 0000", d); end
    checks++; if (leds_val !== 8'h00) begin errors++; $display("FAIL post_rst_leds: got %h want 00", leds_val); end
  endtask

  initial begin
    test_reset();
    test_mask();
    test_ctrl_bits();
    test_pwm_duty();
    test_mid_period();
    test_boundary_write();
    test_disable();
`ifdef LED_PWM_BLINK_EN
    test_blink();
`endif
    test_reset_mid();
    test_post_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
